// File: rtl/fetch_branch_unit.sv
// fetch_branch_unit
//   Datapath-side partner of the multicycle controller. It holds the program
//   counter, the instruction register that feeds the controller's opcode, and
//   the processor status word. It also evaluates branch conditions against the
//   registered PSW.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   IRWrite          load mem_rdata into opcode and count a retired fetch
//   PCWrite          unconditional PC load
//   Branch           conditional PC load, condition in opcode[11:8]
//   PSWEn            load alu_flags into psw
//   IorD             memory address select (0: pc, 1: alu_out)
//   PCSrc            next-PC source select
//   JAorJR           jump type for PCSrc=10 (0: absolute field, 1: reg_a)
//   alu_result       combinational ALU output
//   alu_out          registered ALU output
//   reg_a            register-file read port A
//   alu_flags        {N,Z,C,V} from the ALU
//   mem_rdata        memory read data
//   opcode, pc, psw  architectural registers
//   mem_addr         combinational memory address
//   branch_taken     Branch & cond_true
//   instret          retired-fetch counter (wraps)
module fetch_branch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned JA_BITS  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic        Branch,
  input  logic        PSWEn,
  input  logic        IorD,
  input  logic [1:0]  PCSrc,
  input  logic        JAorJR,
  input  logic [15:0] alu_result,
  input  logic [15:0] alu_out,
  input  logic [15:0] reg_a,
  input  logic [3:0]  alu_flags,
  input  logic [15:0] mem_rdata,
  output logic [15:0] opcode,
  output logic [15:0] pc,
  output logic [15:0] mem_addr,
  output logic [3:0]  psw,
  output logic        branch_taken,
  output logic [15:0] instret
);

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC,
    COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT,
    COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  typedef enum logic [1:0] {
    SRC_ALU    = 2'b00,
    SRC_ALUOUT = 2'b01,
    SRC_JUMP   = 2'b10,
    SRC_HOLD   = 2'b11
  } pc_src_e;

  // Low JA_BITS of the PC come from the instruction on an absolute jump;
  // the upper bits are kept from the current PC.
  localparam logic [15:0] JA_MASK = 16'((32'd1 << JA_BITS) - 32'd1);

  logic        n, z, c, v;
  logic        cond_true;
  logic        pc_en;
  logic [15:0] pc_next;
  cond_e       cond;
  pc_src_e     pc_src;

  assign {n, z, c, v} = psw;
  assign cond         = cond_e'(opcode[11:8]);
  assign pc_src       = pc_src_e'(PCSrc);

  // Conditions look at the registered psw only, so a PSWEn in the same
  // cycle as a Branch cannot influence that branch.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = z;
      COND_NE: cond_true = !z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = !c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = !n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = !v;
      COND_HI: cond_true = c & !z;
      COND_LS: cond_true = !c | z;
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = !z & (n == v);
      COND_LE: cond_true = z | (n != v);
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  assign branch_taken = Branch & cond_true;
  assign pc_en        = PCWrite | branch_taken;
  assign mem_addr     = IorD ? alu_out : pc;

  always_comb begin
    pc_next = pc;
    case (pc_src)
      SRC_ALU:    pc_next = alu_result;
      SRC_ALUOUT: pc_next = alu_out;
      SRC_JUMP:   pc_next = JAorJR ? reg_a : ((pc & ~JA_MASK) | (opcode & JA_MASK));
      SRC_HOLD:   pc_next = pc;
      default:    pc_next = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      opcode  <= '0;
      psw     <= '0;
      instret <= '0;
    end else begin
      if (pc_en) begin
        pc <= pc_next;
      end
      if (IRWrite) begin
        opcode  <= mem_rdata;
        instret <= instret + 16'd1;
      end
      if (PSWEn) begin
        psw <= alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Directed bench for fetch_branch_unit: reset, fetch, branches, condition
// table sweep, jumps, PSW/branch race, reset during a fetch, instret wrap.
module tb_fetch_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IRWrite, PCWrite, Branch, PSWEn, IorD, JAorJR;
  logic [1:0]  PCSrc;
  logic [15:0] alu_result, alu_out, reg_a, mem_rdata;
  logic [3:0]  alu_flags;
  logic [15:0] opcode, pc, mem_addr, instret;
  logic [3:0]  psw;
  logic        branch_taken;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [15:0] exp_instret = '0;

  // Truth mask per condition: bit p set when the condition holds for psw=p.
  logic [15:0] cond_mask [16] = '{
    16'hF0F0, 16'h0F0F, 16'hCCCC, 16'h3333,
    16'hFF00, 16'h00FF, 16'hAAAA, 16'h5555,
    16'h0C0C, 16'hF3F3, 16'hAA55, 16'h55AA,
    16'h0A05, 16'hF5FA, 16'hFFFF, 16'h0000
  };

  fetch_branch_unit #(.RESET_PC(16'h0000), .JA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .PSWEn(PSWEn),
    .IorD(IorD), .PCSrc(PCSrc), .JAorJR(JAorJR),
    .alu_result(alu_result), .alu_out(alu_out), .reg_a(reg_a),
    .alu_flags(alu_flags), .mem_rdata(mem_rdata),
    .opcode(opcode), .pc(pc), .mem_addr(mem_addr), .psw(psw),
    .branch_taken(branch_taken), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IRWrite = 1'b0; PCWrite = 1'b0; Branch = 1'b0; PSWEn = 1'b0;
    IorD = 1'b0; PCSrc = 2'b11; JAorJR = 1'b0;
  endtask

  task automatic load_pc(input logic [15:0] val);
    PCWrite = 1'b1; PCSrc = 2'b00; alu_result = val;
    step();
    idle();
  endtask

  task automatic load_ir(input logic [15:0] val);
    IRWrite = 1'b1; mem_rdata = val;
    step();
    exp_instret = exp_instret + 16'd1;
    idle();
  endtask

  task automatic load_psw(input logic [3:0] val);
    PSWEn = 1'b1; alu_flags = val;
    step();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    alu_result = '0; alu_out = '0; reg_a = '0; alu_flags = '0; mem_rdata = '0;
    step();
    step();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_opcode", opcode, 16'h0000);
    chk("rst_psw", {12'h0, psw}, 16'h0000);
    chk("rst_instret", instret, 16'h0000);
    chk("rst_mem_addr", mem_addr, 16'h0000);

    // Fetch
    rst_n = 1'b1;
    IRWrite = 1'b1; PCWrite = 1'b1; PCSrc = 2'b00; IorD = 1'b0;
    mem_rdata = 16'h1025; alu_result = 16'h0001;
    #1;
    chk("fetch_addr_pre", mem_addr, 16'h0000);
    step();
    exp_instret = exp_instret + 16'd1;
    idle();
    chk("fetch_opcode", opcode, 16'h1025);
    chk("fetch_pc", pc, 16'h0001);
    chk("fetch_instret", instret, exp_instret);
    IorD = 1'b1; alu_out = 16'h5A5A;
    #1;
    chk("addr_iord1", mem_addr, 16'h5A5A);
    idle();

    // BEQ taken
    load_psw(4'b0100);
    chk("psw_load", {12'h0, psw}, 16'h0004);
    load_ir(16'hC003);
    Branch = 1'b1; PCSrc = 2'b01; alu_out = 16'h0016;
    #1;
    chk("beq_taken", {15'h0, branch_taken}, 16'h0001);
    step();
    idle();
    chk("beq_pc", pc, 16'h0016);

    // BEQ not taken
    load_psw(4'b0000);
    Branch = 1'b1; PCSrc = 2'b01; alu_out = 16'h0040;
    #1;
    chk("beq_not_taken", {15'h0, branch_taken}, 16'h0000);
    step();
    idle();
    chk("beq_pc_hold", pc, 16'h0016);

    // Condition sweep: 16 conditions x 16 psw values
    for (int cc = 0; cc < 16; cc++) begin
      load_ir({4'h0, 4'(cc), 8'h00});
      for (int p = 0; p < 16; p++) begin
        load_psw(4'(p));
        Branch = 1'b1;
        #1;
        chk($sformatf("cond%0d_psw%0d", cc, p), {15'h0, branch_taken},
            {15'h0, cond_mask[cc][p]});
        Branch = 1'b0;
      end
    end
    // Condition true but Branch low must not report taken (cond AL loaded last? NV). Use AL.
    load_ir(16'h0E00);
    #1;
    chk("no_branch_strobe", {15'h0, branch_taken}, 16'h0000);

    // Absolute jump
    load_pc(16'h1210);
    load_ir(16'h8035);
    PCWrite = 1'b1; PCSrc = 2'b10; JAorJR = 1'b0; reg_a = 16'hBEEF;
    step();
    idle();
    chk("jump_abs", pc, 16'h1235);

    // Register jump
    load_pc(16'h1210);
    PCWrite = 1'b1; PCSrc = 2'b10; JAorJR = 1'b1; reg_a = 16'hBEEF;
    step();
    idle();
    chk("jump_reg", pc, 16'hBEEF);

    // PCSrc=11 holds even with PCWrite
    PCWrite = 1'b1; PCSrc = 2'b11; alu_result = 16'h7777;
    step();
    idle();
    chk("pcsrc_hold", pc, 16'hBEEF);

    // PCWrite dominates a false branch (opcode 8035: EQ, psw Z=0)
    load_psw(4'b0000);
    PCWrite = 1'b1; Branch = 1'b1; PCSrc = 2'b01; alu_out = 16'h0321;
    #1;
    chk("pcw_br_taken", {15'h0, branch_taken}, 16'h0000);
    step();
    idle();
    chk("pcw_dominates", pc, 16'h0321);

    // Flag race: old Z decides the branch
    load_psw(4'b0100);
    load_ir(16'hC003);
    PSWEn = 1'b1; alu_flags = 4'b0000;
    Branch = 1'b1; PCSrc = 2'b01; alu_out = 16'h0077;
    #1;
    chk("race_taken", {15'h0, branch_taken}, 16'h0001);
    step();
    idle();
    chk("race_pc", pc, 16'h0077);
    chk("race_psw", {12'h0, psw}, 16'h0000);

    // Reset during a fetch
    rst_n = 1'b0;
    IRWrite = 1'b1; PCWrite = 1'b1; PCSrc = 2'b00; PSWEn = 1'b1;
    mem_rdata = 16'hABCD; alu_result = 16'h5555; alu_flags = 4'hF;
    step();
    idle();
    exp_instret = '0;
    chk("midrst_pc", pc, 16'h0000);
    chk("midrst_opcode", opcode, 16'h0000);
    chk("midrst_psw", {12'h0, psw}, 16'h0000);
    chk("midrst_instret", instret, 16'h0000);
    rst_n = 1'b1;

    // instret wrap
    IRWrite = 1'b1; mem_rdata = 16'h0F0F;
    for (int unsigned i = 0; i < 32'd65535; i++) begin
      step();
    end
    exp_instret = 16'hFFFF;
    chk("instret_max", instret, exp_instret);
    step();
    exp_instret = exp_instret + 16'd1;
    idle();
    chk("instret_wrap", instret, exp_instret);
    chk("wrap_opcode", opcode, 16'h0F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_branch_unit.md
# fetch_branch_unit

Datapath-side responder to the multicycle `controller`. It owns the program counter (PC), the instruction register that drives the controller's `opcode` input, and the processor status word (PSW). It also owns the branch-condition logic. Each cycle it consumes the controller's strobes (`IRWrite`, `PCWrite`, `Branch`, `PSWEn`, `IorD`, `PCSrc`, `JAorJR`) and returns the fetched instruction, the memory address and the updated PC.

## Interface
- `RESET_PC`, 16'h0000: PC value after reset.
- `JA_BITS`, 8: width of the absolute jump field `opcode[JA_BITS-1:0]`; legal range 1..12.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `IRWrite`  in  1  latch `mem_rdata` into `opcode`.
- `PCWrite`  in  1  unconditional PC load.
- `Branch`  in  1  conditional PC load; condition field is `opcode[11:8]`.
- `PSWEn`  in  1  latch `alu_flags` into `psw`.
- `IorD`  in  1  address select: 0 selects `pc`, 1 selects `alu_out`.
- `PCSrc`  in  2  next-PC source.
- `JAorJR`  in  1  jump type: 0 = absolute field, 1 = register.
- `alu_result`  in  16  combinational ALU output.
- `alu_out`  in  16  registered ALU output (ALUOut).
- `reg_a`  in  16  register-file read port A.
- `alu_flags`  in  4  {N,Z,C,V} from the ALU.
- `mem_rdata`  in  16  instruction/data memory read data.
- `opcode`  out  16  instruction register, wired to `controller.opcode`.
- `pc`  out  16  program counter.
- `mem_addr`  out  16  memory address, combinational.
- `psw`  out  4  {N,Z,C,V}, registered.
- `branch_taken`  out  1  combinational: `Branch & cond_true`.
- `instret`  out  16  count of retired fetches.

## Operation
- **Reset** (`rst_n` = 0 at a rising edge): `pc`=`RESET_PC`, `opcode`=16'h0000, `psw`=4'b0000, `instret`=0. The combinational outputs follow from these values, so `mem_addr`=`RESET_PC` when `IorD`=0. Reset has priority over every strobe in the same cycle, including a fetch in progress.
- **Memory address:** `mem_addr` = `IorD` ? `alu_out` : `pc`.
- **IR load:** if `IRWrite`, then `opcode` ← `mem_rdata` and `instret` ← `instret`+1. `instret` wraps from 16'hFFFF to 0.
- **PSW load:** if `PSWEn`, then `psw` ← `alu_flags`.
- **PC enable:** `pc_en` = `PCWrite` | (`Branch` & `cond_true`).
- **Next-PC source:**
  - `PCSrc`=00: `alu_result` (PC+1 during fetch).
  - `PCSrc`=01: `alu_out` (branch target).
  - `PCSrc`=10: if `JAorJR`=0, the upper `pc` bits `pc[15:JA_BITS]` concatenated with `opcode[JA_BITS-1:0]`; if `JAorJR`=1, `reg_a`.
  - `PCSrc`=11: hold `pc`, even when `pc_en`=1.
- **Condition codes** (`cond_true` is evaluated on the registered `psw`, never on `alu_flags`):
  - 0 EQ: Z. 1 NE: !Z.
  - 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z.
  - A GE: N==V. B LT: N!=V.
  - C GT: !Z&(N==V). D LE: Z|(N!=V).
  - E AL: 1. F NV: 0.
- **Width rule:** all PC arithmetic is done outside this block. Values are loaded verbatim with no truncation or extension; the result wraps at 16 bits by construction.
- **Unused inputs:** `JAorJR` is ignored unless `PCSrc`=10. `opcode[11:8]` is ignored unless `Branch`=1.

## Timing
- Each register updates one edge after its strobe is sampled high. Every register update happens on the same edge.
- **Fetch cycle** (`IRWrite`=1, `PCWrite`=1, `PCSrc`=00, `IorD`=0): at edge N, `opcode` receives `mem_rdata` read at the old `pc`, and `pc` becomes `alu_result`. The controller sees the new opcode in cycle N+1.
- **`PSWEn` and `Branch` in the same cycle:** the branch decision uses the old `psw`. The new flags are visible from the next cycle.
- **`IRWrite` and `PCWrite` in the same cycle:** both take effect. `opcode` captures data addressed by the pre-update `pc`.
- **`Branch`=1 with condition false:** `pc` holds and `branch_taken`=0.
- **`PCWrite` and `Branch` both high:** `PCWrite` dominates, so the PC is loaded regardless of the condition.
- There are no handshakes: strobes are single-cycle and level-sampled. A strobe held high for k cycles causes k updates.

## Test plan
- **Reset and fetch:** with `RESET_PC`=0, hold `rst_n`=0 for 2 edges, then release. Drive a fetch with `mem_rdata`=16'h1025 and `alu_result`=1. Required: `opcode`=16'h1025, `pc`=1, `instret`=1; `mem_addr`=0 before the edge.
- **BEQ both ways:**
  - `PSWEn` with `alu_flags`=4'b0100, then `opcode`=16'hC003, `Branch`=1, `PCSrc`=01, `alu_out`=16'h0016. Required: `pc`=16'h0016 and `branch_taken`=1.
  - Repeat with `psw`=0. Required: `pc` unchanged and `branch_taken`=0.
- **Condition sweep:** for all 16 conditions × all 16 `psw` values, `branch_taken` matches the condition table. Include AL always 1 and NV always 0.
- **Jumps:**
  - `opcode`=16'h8035, `pc`=16'h1210, `PCSrc`=10, `JAorJR`=0, `PCWrite`=1. Required: `pc`=16'h1235.
  - Same with `JAorJR`=1, `reg_a`=16'hBEEF. Required: `pc`=16'hBEEF.
- **Flag race:** set `psw` Z=1. In one cycle drive `PSWEn`=1 with `alu_flags`=0 and a BEQ. Required: the branch is taken (old Z used), and `psw`=0 afterwards.
- **Reset mid-op and wrap:**
  - Assert `rst_n`=0 in the same cycle as `IRWrite`/`PCWrite`. Required: reset values only.
  - Preload `instret`=16'hFFFF, then fetch once. Required: `instret`=0.
